// File: rtl/bg_pattern_pkg.sv
// bg_pattern_pkg: shared definitions for the background pattern source.
//   - PAT_* : encodings of the pattern_sel input
//   - PIX_W / CH_W : pixel width (30 bit RGB) and per-channel width (10 bit)
//   - state_e : source FSM states
//   - cnt_width() : counter width for a modulus, never below 1 bit
package bg_pattern_pkg;

   localparam int unsigned PIX_W = 30;
   localparam int unsigned CH_W  = 10;

   localparam logic [1:0] PAT_SOLID = 2'd0;
   localparam logic [1:0] PAT_GRAD  = 2'd1;
   localparam logic [1:0] PAT_BARS  = 2'd2;
   localparam logic [1:0] PAT_CHECK = 2'd3;

   typedef enum logic {IDLE, RUN} state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bg_pixel_counter.sv
// bg_pixel_counter: raster position of the next pixel to be emitted.
// Tracks x/y plus a bar index driven by a per-bar pixel counter (no divider).
// Optional macro BG_PATTERN_CHECKER_EN adds the checker_bit output.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   step           : advance to the next raster position
//   x              : current column
//   bar            : current bar index modulo 8
//   first / last   : position is (0,0) / (WIDTH-1,HEIGHT-1)
//   checker_bit    : x[3]^y[3] (only with BG_PATTERN_CHECKER_EN)
module bg_pixel_counter
   import bg_pattern_pkg::*;
#(
   parameter int unsigned WIDTH     = 800,
   parameter int unsigned HEIGHT    = 480,
   parameter int unsigned BAR_COUNT = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          step,
   output logic [cnt_width(WIDTH)-1:0]   x,
   output logic [2:0]                    bar,
   output logic                          first,
   output logic                          last
`ifdef BG_PATTERN_CHECKER_EN
   ,
   output logic                          checker_bit
`endif
);

   localparam int unsigned BAR_W = WIDTH / BAR_COUNT;
   localparam int unsigned XW    = cnt_width(WIDTH);
   localparam int unsigned YW    = cnt_width(HEIGHT);
   localparam int unsigned BCW   = cnt_width(BAR_COUNT);
   localparam int unsigned BPW   = cnt_width(BAR_W);

   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;
   logic [BCW-1:0] bar_idx_q;
   logic [BPW-1:0] bar_pix_q;
   logic           x_last;
   logic           y_last;

   assign x_last = (x_q == XW'(WIDTH - 1));
   assign y_last = (y_q == YW'(HEIGHT - 1));
   assign x      = x_q;
   assign bar    = 3'(bar_idx_q);
   assign first  = (x_q == '0) && (y_q == '0);
   assign last   = x_last && y_last;

`ifdef BG_PATTERN_CHECKER_EN
   assign checker_bit = 1'((32'(x_q) ^ 32'(y_q)) >> 3);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q       <= '0;
         y_q       <= '0;
         bar_idx_q <= '0;
         bar_pix_q <= '0;
      end else if (step) begin
         if (x_last) begin
            x_q       <= '0;
            bar_idx_q <= '0;
            bar_pix_q <= '0;
            y_q       <= y_last ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
            if (bar_pix_q == BPW'(BAR_W - 1)) begin
               // The last bar absorbs any remainder pixels of the line.
               if (bar_idx_q != BCW'(BAR_COUNT - 1)) begin
                  bar_idx_q <= bar_idx_q + 1'b1;
                  bar_pix_q <= '0;
               end
            end else begin
               bar_pix_q <= bar_pix_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bg_pattern_source.sv
// bg_pattern_source: Avalon-ST background frame generator (30 bit RGB).
// Emits one packet per frame (solid, gradient, bars, optional checker) with
// full ready/valid backpressure. Optional macro BG_PATTERN_CHECKER_EN enables
// the 8x8 checkerboard on pattern 3; without it pattern 3 is solid.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   enable             : generate frames while high (sampled at frame start)
//   pattern_sel        : 0 solid, 1 gradient, 2 bars, 3 checker
//   solid_color        : {R,G,B} colour for solid mode
//   src_data/sop/eop/valid, src_ready : Avalon-ST source
//   busy               : frame in progress
//   frame_count        : completed frames, wraps at 16 bits
module bg_pattern_source
   import bg_pattern_pkg::*;
#(
   parameter int unsigned WIDTH     = 800,
   parameter int unsigned HEIGHT    = 480,
   parameter int unsigned BAR_COUNT = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   input  logic [PIX_W-1:0] solid_color,
   output logic [PIX_W-1:0] src_data,
   output logic             src_startofpacket,
   output logic             src_endofpacket,
   output logic             src_valid,
   input  logic             src_ready,
   output logic             busy,
   output logic [15:0]      frame_count
);

   localparam int unsigned XW = cnt_width(WIDTH);
   localparam logic [CH_W-1:0] CH_MAX = '1;

   state_e           state_q;
   logic [1:0]       shadow_pat_q;
   logic [PIX_W-1:0] shadow_color_q;

   logic [XW-1:0]    x;
   logic [2:0]       bar;
   logic             first;
   logic             last;
   logic             load_ok;
   logic             frame_done;
   logic             restart;
   logic             step;
   logic [1:0]       pat_eff;
   logic [PIX_W-1:0] color_eff;
   logic [CH_W-1:0]  grad;
   logic [PIX_W-1:0] pixel;
`ifdef BG_PATTERN_CHECKER_EN
   logic             checker_bit;
`endif

   bg_pixel_counter #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .BAR_COUNT (BAR_COUNT)
   ) u_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .step        (step),
      .x           (x),
      .bar         (bar),
      .first       (first),
      .last        (last)
`ifdef BG_PATTERN_CHECKER_EN
      ,
      .checker_bit (checker_bit)
`endif
   );

   assign load_ok    = !src_valid || src_ready;
   assign frame_done = src_valid && src_ready && src_endofpacket;
   // Back-to-back frame: pixel (0,0) is built from the live inputs in the
   // same cycle the shadow registers capture them.
   assign restart    = frame_done && enable;
   assign step       = (state_q == RUN) && load_ok && !(frame_done && !enable);
   assign pat_eff    = restart ? pattern_sel : shadow_pat_q;
   assign color_eff  = restart ? solid_color : shadow_color_q;
   assign grad       = CH_W'(x);

   always_comb begin
      pixel = color_eff;
      case (pat_eff)
         PAT_SOLID: pixel = color_eff;
         PAT_GRAD:  pixel = {grad, grad, grad};
         PAT_BARS:  pixel = {bar[2] ? CH_MAX : '0, bar[1] ? CH_MAX : '0, bar[0] ? CH_MAX : '0};
`ifdef BG_PATTERN_CHECKER_EN
         PAT_CHECK: pixel = checker_bit ? '1 : '0;
`endif
         default:   pixel = color_eff;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q           <= IDLE;
         shadow_pat_q      <= '0;
         shadow_color_q    <= '0;
         src_data          <= '0;
         src_startofpacket <= 1'b0;
         src_endofpacket   <= 1'b0;
         src_valid         <= 1'b0;
         busy              <= 1'b0;
         frame_count       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  shadow_pat_q   <= pattern_sel;
                  shadow_color_q <= solid_color;
                  state_q        <= RUN;
               end
            end
            RUN: begin
               if (load_ok) begin
                  if (frame_done && !enable) begin
                     src_data          <= '0;
                     src_startofpacket <= 1'b0;
                     src_endofpacket   <= 1'b0;
                     src_valid         <= 1'b0;
                     busy              <= 1'b0;
                     state_q           <= IDLE;
                  end else begin
                     src_data          <= pixel;
                     src_startofpacket <= first;
                     src_endofpacket   <= last;
                     src_valid         <= 1'b1;
                     busy              <= 1'b1;
                     if (restart) begin
                        shadow_pat_q   <= pattern_sel;
                        shadow_color_q <= solid_color;
                     end
                  end
                  if (frame_done) begin
                     frame_count <= frame_count + 16'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bg_pattern_source.sv
// tb_bg_pattern_source: randomized bench for bg_pattern_source (4x2, 2 bars).
// A frame-index reference model predicts every output after each clock edge.
module tb_bg_pattern_source;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int BC = 2;
   localparam int N  = W * H;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [29:0] solid_color;
   logic [29:0] src_data;
   logic        src_startofpacket;
   logic        src_endofpacket;
   logic        src_valid;
   logic        src_ready;
   logic        busy;
   logic [15:0] frame_count;

   bg_pattern_source #(
      .WIDTH     (W),
      .HEIGHT    (H),
      .BAR_COUNT (BC)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .enable            (enable),
      .pattern_sel       (pattern_sel),
      .solid_color       (solid_color),
      .src_data          (src_data),
      .src_startofpacket (src_startofpacket),
      .src_endofpacket   (src_endofpacket),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .busy              (busy),
      .frame_count       (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: frame-level view of the source.
   bit          m_run;
   int          m_idx;
   logic [1:0]  m_pat;
   logic [29:0] m_col;
   logic        e_valid, e_sop, e_eop, e_busy;
   logic [29:0] e_data;
   logic [15:0] e_fc;
   logic        m_rst_seen;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] ref_pixel(input logic [1:0] p, input logic [29:0] c,
                                             input int x, input int y);
      logic [9:0] g;
      int b;
      case (p)
         2'd1: begin
            g = 10'(x % 1024);
            return {g, g, g};
         end
         2'd2: begin
            b = x / (W / BC);
            if (b > BC - 1) b = BC - 1;
            b = b % 8;
            return {((b & 4) != 0) ? 10'h3FF : 10'h0,
                    ((b & 2) != 0) ? 10'h3FF : 10'h0,
                    ((b & 1) != 0) ? 10'h3FF : 10'h0};
         end
`ifdef BG_PATTERN_CHECKER_EN
         2'd3: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 30'h3FFFFFFF : 30'h0;
`endif
         default: begin
            if (y < 0) return 30'h0;
            return c;
         end
      endcase
   endfunction

   task automatic present();
      e_valid = 1'b1;
      e_busy  = 1'b1;
      e_sop   = (m_idx == 0);
      e_eop   = (m_idx == N - 1);
      e_data  = ref_pixel(m_pat, m_col, m_idx % W, m_idx / W);
   endtask

   task automatic go_idle();
      m_run   = 0;
      e_valid = 1'b0;
      e_sop   = 1'b0;
      e_eop   = 1'b0;
      e_busy  = 1'b0;
      e_data  = '0;
   endtask

   // Predict the outputs after the coming clock edge from the inputs now driven.
   task automatic model_step();
      m_rst_seen = !reset_n;
      if (!reset_n) begin
         go_idle();
         m_idx = 0;
         m_pat = '0;
         m_col = '0;
         e_fc  = '0;
      end else if (!m_run) begin
         if (enable) begin
            m_run = 1;
            m_idx = 0;
            m_pat = pattern_sel;
            m_col = solid_color;
         end
      end else if (!e_valid) begin
         present();
      end else if (src_ready) begin
         if (m_idx == N - 1) begin
            e_fc = e_fc + 16'd1;
            if (enable) begin
               m_pat = pattern_sel;
               m_col = solid_color;
               m_idx = 0;
               present();
            end else begin
               go_idle();
            end
         end else begin
            m_idx++;
            present();
         end
      end
   endtask

   task automatic compare();
      check_eq("ctl {valid,busy,sop,eop}",
               {60'd0, src_valid, busy, src_valid & src_startofpacket,
                src_valid & src_endofpacket},
               {60'd0, e_valid, e_busy, e_valid & e_sop, e_valid & e_eop});
      if (e_valid || m_rst_seen) check_eq("data", {34'd0, src_data}, {34'd0, e_data});
      check_eq("frame_count", {48'd0, frame_count}, {48'd0, e_fc});
   endtask

   task automatic step_cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic run(input int n, input int en_pct, input int rdy_pct, input bit rnd_cfg);
      for (int i = 0; i < n; i++) begin
         enable    = ($urandom_range(99) < en_pct);
         src_ready = ($urandom_range(99) < rdy_pct);
         if (rnd_cfg) begin
            pattern_sel = 2'($urandom);
            solid_color = 30'($urandom);
         end
         step_cycle();
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      solid_color = '0;
      src_ready   = 1'b1;
      m_run       = 0;
      m_idx       = 0;
      m_pat       = '0;
      m_col       = '0;
      e_fc        = '0;
      m_rst_seen  = 1'b1;
      go_idle();
      @(negedge clk);

      run(3, 0, 100, 0);                       // reset state
      reset_n = 1'b1;
      run(2, 0, 100, 0);                       // idle with enable low

      pattern_sel = 2'd0;                      // solid; enable dropped mid-frame
      solid_color = 30'h12345678 & 30'h3FFFFFFF;
      run(4, 100, 100, 0);
      run(12, 0, 100, 0);

      pattern_sel = 2'd1;                      // gradient with random stalls
      run(40, 100, 50, 0);
      run(24, 0, 100, 0);

      pattern_sel = 2'd2;                      // colour bars, two frames
      run(18, 100, 100, 0);
      run(12, 0, 100, 0);

      pattern_sel = 2'd3;                      // pattern 3
      solid_color = 30'h2AB_CDE_F1;
      run(12, 100, 100, 0);
      run(12, 0, 100, 0);

      run(60, 100, 70, 1);                     // config churn mid-frame

      pattern_sel = 2'd1;                      // reset pulse mid-frame
      run(5, 100, 100, 0);
      reset_n = 1'b0;
      run(1, 100, 100, 0);
      reset_n = 1'b1;
      run(20, 100, 80, 0);

      run(400, 80, 60, 1);                     // everything random
      run(30, 0, 100, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bg_pattern_source.md
Name: bg_pattern_source

Overview:
- Avalon-ST video source that generates full background frames for the alpha-blending stage's background sink (30-bit RGB, 10 bits per colour).
- Sits directly upstream of that sink. Frame geometry matches the 800x480 MTL panel by default.
- Produces one packet per frame: solid colour, horizontal gradient or colour bars, with full ready/valid backpressure.

Parameters:
- WIDTH, 800, active pixels per line (>=2).
- HEIGHT, 480, lines per frame (>=1).
- BAR_COUNT, 8, number of vertical colour bars; BAR_W = WIDTH/BAR_COUNT (integer, must be >=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- enable  in  1  level; generate frames while high
- pattern_sel  in  2  0 solid, 1 gradient, 2 bars, 3 checker (feature-gated)
- solid_color  in  30  {R[29:20],G[19:10],B[9:0]} for solid mode
- src_data  out  30  pixel
- src_startofpacket  out  1  first pixel of frame
- src_endofpacket  out  1  last pixel of frame
- src_valid  out  1  pixel valid
- src_ready  in  1  sink accepts pixel
- busy  out  1  frame in progress
- frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous, active low. On reset, all outputs are 0; state IDLE; x=y=0; bar counters 0.
- Transfer rule: a transfer occurs when src_valid && src_ready.
  - Output registers load the next pixel when !src_valid || src_ready.
  - While src_valid=1 && src_ready=0, src_data, sop, eop and src_valid hold stable.
- FSM IDLE: while enable=0, src_valid=0 and busy=0.
  - On enable=1, latch pattern_sel and solid_color into shadow registers.
  - Next cycle: present pixel (0,0) with sop=1, src_valid=1, busy=1; go to RUN. First-pixel latency is 1 cycle after enable is sampled.
- FSM RUN: each transfer advances x. At x=WIDTH-1, x wraps to 0 and y increments.
  - eop=1 exactly on pixel (WIDTH-1, HEIGHT-1).
  - sop is high only on (0,0).
  - When the eop pixel transfers, frame_count increments (16-bit wrap).
  - If enable=1 after the eop transfer: re-latch config; pixel (0,0) of the next frame is presented in the same cycle as the register load, with no bubble.
  - If enable=0 after the eop transfer: src_valid=0, return to IDLE.
- enable deasserted mid-frame: ignored until the frame completes. Partial frames are never emitted.
- Config changes mid-frame: ignored. The shadow registers are used for the whole frame.
- Pattern arithmetic:
  - solid: src_data = shadow colour.
  - gradient: R=G=B=x[9:0]; wraps modulo 1024 if WIDTH>1024.
  - bars: bar index b increments every BAR_W pixels using a separate counter (no divider). Colour is {b[2]?10'h3FF:0, b[1]?10'h3FF:0, b[0]?10'h3FF:0} with b taken modulo 8. Pixels beyond BAR_COUNT*BAR_W keep the last bar. Bar counters reset at each line start.
  - pattern 3 with the feature absent: behaves as solid.
- HEIGHT=1: sop and eop both occur on line 0; eop is on x=WIDTH-1.

Optional Feature:
- Macro: BG_PATTERN_CHECKER_EN.
- Defined: pattern 3 gives an 8x8 checkerboard, src_data = (x[3]^y[3]) ? 30'h3FFFFFFF : 30'h0.
- Undefined: pattern 3 maps to solid. No y[3]-based logic is synthesised.

Decomposition:
- Package bg_pattern_pkg holds:
  - pattern encodings PAT_SOLID/PAT_GRAD/PAT_BARS/PAT_CHECK;
  - pixel width 30 and channel width 10;
  - FSM state typedef {IDLE, RUN}.
- One natural sub-module, bg_pixel_counter: x/y/bar counters with sop/eop flag generation, advanced by a single step input.
- Pattern mux and output register stay in the top.

Test Plan (WIDTH=4, HEIGHT=2, BAR_COUNT=2 unless stated):
- Solid mode, solid_color=30'h12345678 masked to 30 bits, enable=1, src_ready=1 -> 8 pixels all equal to the colour; sop on beat 0; eop on beat 7; frame_count=1; first valid 1 cycle after enable.
- Gradient with random src_ready stalls -> data sequence 0,0x00100401,0x00200802,0x00300C03 repeated per line. Outputs stay stable while stalled; no pixel is dropped or duplicated.
- Bars -> line pixels 0,0,0x3FF,0x3FF (b=0,0,1,1 → B channel only); bar counter restarts on line 1.
- enable dropped at beat 3 -> frame completes through eop, then src_valid=0, busy=0, frame_count=1.
- enable held for 3 frames with pattern_sel changed mid-frame 2 -> frame 2 is unchanged, frame 3 uses the new pattern; back-to-back sop follows eop with no idle cycle.
- reset_n low mid-frame for 1 cycle -> next cycle all outputs are 0 and frame_count=0. After release with enable=1, a fresh frame starts at sop.
